mem_arbiter: RTL and testbench

- Shares one unified memory port between the CPU instruction-fetch requester (imem) and the data requester (dmem).
- Sits between the CPU and a single merged memory; uses the same valid/good handshake on both sides.
- Round-robin arbitration; one transaction outstanding at a time.
- Watchdog timeout returns an error response when memory never answers.

---
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the two CPU requesters, the arbiter and the merged memory.
// slave is the arbiter's view; master is the CPU-plus-memory environment's view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_valid;
    logic              imem_good;
    logic [DATA_W-1:0] imem_instr;
    logic              imem_err;

    logic [ADDR_W-1:0] dmem_addr;
    logic              dmem_valid;
    logic [DATA_W-1:0] dmem_writeData;
    logic              dmem_memRead;
    logic              dmem_memWrite;
    logic [1:0]        dmem_maskMode;
    logic              dmem_sext;
    logic              dmem_good;
    logic [DATA_W-1:0] dmem_readData;
    logic              dmem_err;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        mem_maskMode;
    logic              mem_sext;
    logic              mem_good;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  imem_addr, imem_valid,
        output imem_good, imem_instr, imem_err,
        input  dmem_addr, dmem_valid, dmem_writeData, dmem_memRead, dmem_memWrite,
        input  dmem_maskMode, dmem_sext,
        output dmem_good, dmem_readData, dmem_err,
        output mem_addr, mem_valid, mem_wdata, mem_read, mem_write, mem_maskMode, mem_sext,
        input  mem_good, mem_rdata
    );

    modport master (
        output imem_addr, imem_valid,
        input  imem_good, imem_instr, imem_err,
        output dmem_addr, dmem_valid, dmem_writeData, dmem_memRead, dmem_memWrite,
        output dmem_maskMode, dmem_sext,
        input  dmem_good, dmem_readData, dmem_err,
        input  mem_addr, mem_valid, mem_wdata, mem_read, mem_write, mem_maskMode, mem_sext,
        output mem_good, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Latency: request sampled at t, mem_valid at t+1, good pulse no earlier than t+2; one transaction in flight.
// Backpressure: requesters hold valid until their good pulse; a silent memory is cut off by the watchdog.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              read;
        logic              write;
        logic [1:0]        mask;
        logic              sext;
    } mem_req_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    mem_req_t          mem_req_q, mem_req_d;
    logic              mem_valid_q, mem_valid_d;
    logic              imem_good_q, imem_good_d;
    logic [DATA_W-1:0] imem_instr_q, imem_instr_d;
    logic              imem_err_q, imem_err_d;
    logic              dmem_good_q, dmem_good_d;
    logic [DATA_W-1:0] dmem_rdata_q, dmem_rdata_d;
    logic              dmem_err_q, dmem_err_d;

    logic              grant_vld;
    logic              grant_dmem;
    logic              busy_done;
    logic              timed_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_D;
            cnt_q        <= '0;
            mem_req_q    <= '0;
            mem_valid_q  <= 1'b0;
            imem_good_q  <= 1'b0;
            imem_instr_q <= '0;
            imem_err_q   <= 1'b0;
            dmem_good_q  <= 1'b0;
            dmem_rdata_q <= '0;
            dmem_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_valid_q  <= mem_valid_d;
            imem_good_q  <= imem_good_d;
            imem_instr_q <= imem_instr_d;
            imem_err_q   <= imem_err_d;
            dmem_good_q  <= dmem_good_d;
            dmem_rdata_q <= dmem_rdata_d;
            dmem_err_q   <= dmem_err_d;
        end
    end

    // On a tie, the requester that was not granted last wins.
    always_comb begin
        grant_vld    = bus.imem_valid || bus.dmem_valid;
        grant_dmem   = bus.dmem_valid && (!bus.imem_valid || (last_grant_q == GRANT_I));
        timed_out    = !bus.mem_good && (cnt_q == CNT_W'(TIMEOUT));
        busy_done    = bus.mem_good || timed_out;
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d      = grant_dmem ? BUSY_D : BUSY_I;
                    last_grant_d = grant_dmem;
                    cnt_d        = CNT_W'(1);
                end
            end
            BUSY_I, BUSY_D: begin
                if (busy_done) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_d    = mem_req_q;
        mem_valid_d  = mem_valid_q;
        imem_good_d  = 1'b0;
        imem_instr_d = imem_instr_q;
        imem_err_d   = imem_err_q;
        dmem_good_d  = 1'b0;
        dmem_rdata_d = dmem_rdata_q;
        dmem_err_d   = dmem_err_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    mem_valid_d = 1'b1;
                    if (grant_dmem) begin
                        mem_req_d.addr  = bus.dmem_addr;
                        mem_req_d.wdata = bus.dmem_writeData;
                        mem_req_d.read  = bus.dmem_memRead;
                        mem_req_d.write = bus.dmem_memWrite;
                        mem_req_d.mask  = bus.dmem_maskMode;
                        mem_req_d.sext  = bus.dmem_sext;
                    end else begin
                        // Fetches are always plain word reads.
                        mem_req_d.addr  = bus.imem_addr;
                        mem_req_d.wdata = '0;
                        mem_req_d.read  = 1'b1;
                        mem_req_d.write = 1'b0;
                        mem_req_d.mask  = 2'b10;
                        mem_req_d.sext  = 1'b0;
                    end
                end
            end
            BUSY_I: begin
                if (busy_done) begin
                    mem_valid_d  = 1'b0;
                    mem_req_d    = '0;
                    imem_good_d  = 1'b1;
                    imem_err_d   = timed_out;
                    imem_instr_d = timed_out ? '0 : bus.mem_rdata;
                end
            end
            BUSY_D: begin
                if (busy_done) begin
                    mem_valid_d  = 1'b0;
                    mem_req_d    = '0;
                    dmem_good_d  = 1'b1;
                    dmem_err_d   = timed_out;
                    dmem_rdata_d = (timed_out || !mem_req_q.read) ? '0 : bus.mem_rdata;
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_addr      = mem_req_q.addr;
    assign bus.mem_wdata     = mem_req_q.wdata;
    assign bus.mem_read      = mem_req_q.read;
    assign bus.mem_write     = mem_req_q.write;
    assign bus.mem_maskMode  = mem_req_q.mask;
    assign bus.mem_sext      = mem_req_q.sext;
    assign bus.mem_valid     = mem_valid_q;
    assign bus.imem_good     = imem_good_q;
    assign bus.imem_instr    = imem_instr_q;
    assign bus.imem_err      = imem_err_q;
    assign bus.dmem_good     = dmem_good_q;
    assign bus.dmem_readData = dmem_rdata_q;
    assign bus.dmem_err      = dmem_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: requester drivers and a latency-controlled memory push expected
// completions into per-requester queues; a posedge monitor pops and compares every good pulse.
module tb_mem_arbiter;
    localparam int TMO = 4;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        care;
        int          cyc;
    } exp_t;

    typedef struct {
        int who;
        int cyc;
    } log_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    exp_t exp_i_q[$];
    exp_t exp_d_q[$];
    log_t good_log[$];

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .CNT_W(3)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [68:0] mem_bus();
        return {bus.mem_addr, bus.mem_wdata, bus.mem_read, bus.mem_write, bus.mem_maskMode, bus.mem_sext};
    endfunction

    // Monitor: every good pulse must match the oldest outstanding expectation; data holds otherwise.
    logic [31:0] li_data, ld_data;
    logic        li_err, ld_err, ld_care;
    exp_t        me;
    log_t        ml;
    always @(posedge clk) begin
        #1;
        if (reset) begin
            exp_i_q.delete();
            exp_d_q.delete();
            li_data = 0; li_err = 0; ld_data = 0; ld_err = 0; ld_care = 1;
        end else begin
            if (bus.imem_good) begin
                ml.who = 0; ml.cyc = cyc; good_log.push_back(ml);
                if (exp_i_q.size() == 0) chk("imem_good unexpected", 1, 0);
                else begin
                    me = exp_i_q.pop_front();
                    chk("imem_instr", bus.imem_instr, me.data);
                    chk("imem_err", bus.imem_err, me.err);
                    chk("imem_good cycle", cyc, me.cyc);
                    li_data = me.data; li_err = me.err;
                end
            end else begin
                chk("imem hold", {bus.imem_err, bus.imem_instr}, {li_err, li_data});
            end
            if (bus.dmem_good) begin
                ml.who = 1; ml.cyc = cyc; good_log.push_back(ml);
                if (exp_d_q.size() == 0) chk("dmem_good unexpected", 1, 0);
                else begin
                    me = exp_d_q.pop_front();
                    if (me.care) chk("dmem_readData", bus.dmem_readData, me.data);
                    chk("dmem_err", bus.dmem_err, me.err);
                    chk("dmem_good cycle", cyc, me.cyc);
                    ld_data = me.data; ld_err = me.err; ld_care = me.care;
                end
            end else begin
                chk("dmem_err hold", bus.dmem_err, ld_err);
                if (ld_care) chk("dmem_readData hold", bus.dmem_readData, ld_data);
            end
            if (!bus.mem_valid) chk("mem_* zero while idle", mem_bus(), 0);
        end
    end

    // Requester and memory model state (owned by the stimulus process only).
    logic        i_vld = 0, d_vld = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
    logic        d_rd = 0, d_wr = 0, d_sext = 0;
    logic [1:0]  d_mask = 0;
    int          i_gap = 0, d_gap = 0, i_wait = 0, d_wait = 0;
    logic        last_g = 1'b1;
    logic        m_act = 0;
    int          m_k = 0, m_w = 0, m_nb = 0;
    logic [31:0] m_rd = 0;
    logic [68:0] f_req = 0;
    logic        issue_en = 0, b2b = 0;
    int          force_w = -1;

    function automatic int pick_w();
        int r;
        r = int'($urandom % 10);
        return (r < 6) ? (r % 4) : (r - 2);
    endfunction

    task automatic new_i();
        i_vld = 1; i_addr = $urandom; i_wait = 0;
    endtask

    task automatic new_d();
        int k;
        k = int'($urandom % 8);
        d_vld = 1; d_addr = $urandom; d_wdata = $urandom; d_wait = 0;
        d_rd = (k < 4); d_wr = (k >= 4 && k < 7);
        d_mask = 2'(($urandom % 3)); d_sext = 1'($urandom % 2);
    endtask

    task automatic drive_bus();
        bus.imem_valid = i_vld; bus.imem_addr = i_addr;
        bus.dmem_valid = d_vld; bus.dmem_addr = d_addr; bus.dmem_writeData = d_wdata;
        bus.dmem_memRead = d_rd; bus.dmem_memWrite = d_wr;
        bus.dmem_maskMode = d_mask; bus.dmem_sext = d_sext;
    endtask

    // One negedge step: observe a new memory transaction, play the memory, then advance the requesters.
    task automatic eng_step();
        exp_t e;
        logic g;
        if (bus.mem_valid && !m_act) begin
            g = (i_vld && d_vld) ? !last_g : d_vld;
            last_g = g;
            m_act = 1; m_k = 0;
            m_w = (force_w >= 0) ? force_w : pick_w();
            m_nb = (m_w + 1 < TMO) ? m_w + 1 : TMO;
            m_rd = $urandom;
            if (g) f_req = {d_addr, d_wdata, d_rd, d_wr, d_mask, d_sext};
            else   f_req = {i_addr, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0};
            e.err  = (m_w >= TMO);
            e.care = e.err || !g || d_rd || d_wr;
            e.data = (e.err || (g && !d_rd)) ? 32'h0 : m_rd;
            e.cyc  = cyc + m_nb;
            if (g) exp_d_q.push_back(e); else exp_i_q.push_back(e);
        end
        if (m_act && m_k < m_nb) begin
            chk("mem_valid held", bus.mem_valid, 1);
            chk("mem fwd", mem_bus(), f_req);
        end else if (m_act) begin
            chk("mem_valid released", bus.mem_valid, 0);
        end
        bus.mem_good = 0; bus.mem_rdata = $urandom;
        if (m_act) begin
            if (m_k == m_w) begin
                bus.mem_good = 1; bus.mem_rdata = m_rd; m_act = 0;
            end else if (m_k >= 5) begin
                m_act = 0;
            end
            m_k++;
        end
        if (i_vld) begin
            i_wait++;
            if (bus.imem_good) begin
                if (issue_en && (b2b || $urandom % 2 == 0)) new_i();
                else begin i_vld = 0; i_gap = int'($urandom % 4); end
            end else if (i_wait > 40) begin
                chk("imem request starved", i_wait, 0); i_wait = 0;
            end
        end else if (issue_en) begin
            if (i_gap == 0) new_i(); else i_gap--;
        end
        if (d_vld) begin
            d_wait++;
            if (bus.dmem_good) begin
                if (issue_en && (b2b || $urandom % 2 == 0)) new_d();
                else begin d_vld = 0; d_gap = int'($urandom % 4); end
            end else if (d_wait > 40) begin
                chk("dmem request starved", d_wait, 0); d_wait = 0;
            end
        end else if (issue_en) begin
            if (d_gap == 0) new_d(); else d_gap--;
        end
        drive_bus();
    endtask

    task automatic run_engine(input int n);
        repeat (n) begin
            @(negedge clk);
            eng_step();
        end
    endtask

    task automatic wind_down();
        bit done;
        done = 0;
        issue_en = 0; b2b = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            run_engine(1);
            done = !i_vld && !d_vld && !m_act && exp_i_q.size() == 0 && exp_d_q.size() == 0;
        end
        chk("drain completes", done, 1);
        run_engine(6);
    endtask

    task automatic check_tie_log(input string nm, input int n);
        chk({nm, " good count"}, (good_log.size() >= n), 1);
        for (int k = 0; k < n && k < good_log.size(); k++) begin
            chk({nm, " grant order"}, good_log[k].who, k % 2);
            if (k > 0) chk({nm, " good spacing"}, good_log[k].cyc - good_log[k-1].cyc, 3);
        end
    endtask

    initial begin
        i_vld = 0; d_vld = 0; drive_bus();
        bus.mem_good = 0; bus.mem_rdata = 0;
        repeat (3) @(negedge clk);
        chk("reset imem outs", {bus.imem_good, bus.imem_err, bus.imem_instr}, 0);
        chk("reset dmem outs", {bus.dmem_good, bus.dmem_err, bus.dmem_readData}, 0);
        chk("reset mem_valid", bus.mem_valid, 0);
        chk("reset mem_*", mem_bus(), 0);
        reset = 0;

        // Continuous tie with zero-wait memory: strict alternation starting with imem.
        good_log.delete();
        force_w = 0; b2b = 1; issue_en = 1;
        run_engine(14);
        check_tie_log("tie after reset", 4);

        force_w = 3; run_engine(40);        // mem_good coincides with the watchdog limit
        force_w = 4; run_engine(40);        // timeout with a spurious late mem_good
        force_w = -1; b2b = 0; run_engine(3000);
        wind_down();

        // Reset while a store is in flight to a memory that never answers.
        @(negedge clk);
        bus.dmem_valid = 1; bus.dmem_addr = 32'h2000; bus.dmem_writeData = 32'hDEADBEEF;
        bus.dmem_memRead = 0; bus.dmem_memWrite = 1; bus.dmem_maskMode = 2'b00; bus.dmem_sext = 0;
        @(negedge clk);
        bus.dmem_valid = 0;
        chk("store mem_valid", bus.mem_valid, 1);
        chk("store mem fwd", mem_bus(), {32'h2000, 32'hDEADBEEF, 1'b0, 1'b1, 2'b00, 1'b0});
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("mid-reset mem_valid", bus.mem_valid, 0);
        chk("mid-reset dmem outs", {bus.dmem_good, bus.dmem_err, bus.dmem_readData}, 0);
        chk("mid-reset mem_*", mem_bus(), 0);
        bus.mem_good = 1; bus.mem_rdata = 32'h55;
        @(negedge clk);
        bus.mem_good = 0;
        chk("late mem_good ignored", {bus.dmem_good, bus.imem_good}, 0);
        @(negedge clk);
        chk("late mem_good no pulse", {bus.dmem_good, bus.imem_good, bus.mem_valid}, 0);

        // After reset the first tie must again go to imem.
        last_g = 1; m_act = 0; i_gap = 0; d_gap = 0;
        good_log.delete();
        force_w = 0; b2b = 1; issue_en = 1;
        run_engine(14);
        check_tie_log("tie after mid reset", 4);
        wind_down();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end
endmodule
